spi_frame_ctrl: RTL and testbench
=================================

SPI_FRAME_CTRL -- requirements
Module: spi_frame_ctrl

Interface
REQ-001 SHALL have parameter EN_WIDTH, default 2, meaning clk cycles the en strobe is held high on a write (legal 1..15).
REQ-002 SHALL have parameter SYNC_STAGES, default 2, meaning synchronizer depth on sck/cs_n/mosi (legal 2..3).
REQ-003 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port sck  input  1  SPI serial clock, mode 0 (CPOL=0, CPHA=0), asynchronous to clk.
REQ-006 SHALL have port cs_n  input  1  SPI chip select, active-low.
REQ-007 SHALL have port mosi  input  1  SPI data in, MSB first.
REQ-008 SHALL have port miso  output  1  SPI data out, MSB first.
REQ-009 SHALL have port en  output  1  register strobe to the 8-line port; the port captures on its rising edge.
REQ-010 SHALL have port rw  output  1  1=read, 0=write, toward the port.
REQ-011 SHALL have port regSel  output  4  port register select.
REQ-012 SHALL have port dataOut  output  8  write data toward the port dataBus.
REQ-013 SHALL have port dataOe  output  1  1 = dataOut drives the port dataBus (external tri-state control).
REQ-014 SHALL have port dataIn  input  8  port dataBus as read back.
REQ-015 SHALL have port frameErr  output  1  one-clk pulse on a rejected frame.

Function
REQ-016 SHALL use a 16-bit frame: byte 0 = command {rw, 3'b000, regSel[3:0]}, byte 1 = data; edges detected on synchronized sck (rise = sample mosi, fall = update miso).
REQ-017 SHALL implement states IDLE, CMD, DATA, WSETUP, WSTROBE, WHOLD, WAITCS.
REQ-018 IDLE->CMD SHALL occur on synchronized cs_n falling; bit counter cleared to 0.
REQ-019 CMD SHALL shift 8 mosi bits on sck rise; on 8th bit: if bits[6:4]!=0 -> pulse frameErr, go WAITCS; else latch rw/regSel onto outputs, go DATA.
REQ-020 On a read command, one clk after regSel/rw are valid, SHALL capture dataIn into the miso shift register; miso SHALL present bit 7 before the first data-byte sck rise and shift on each sck fall.
REQ-021 DATA SHALL shift 8 mosi bits; on 16th bit: read -> go WAITCS with no en pulse; write -> latch data into dataOut, go WSETUP.
REQ-022 WSETUP SHALL last 1 clk with dataOe=1, en=0; WSTROBE SHALL hold en=1 for EN_WIDTH clks; WHOLD SHALL last 1 clk with en=0, dataOe=1; then dataOe=0, go WAITCS.
REQ-023 WAITCS SHALL ignore all further sck/mosi and return to IDLE when synchronized cs_n is high.
REQ-024 cs_n rising in CMD or DATA SHALL abort: no en pulse, no frameErr, counters cleared, go IDLE.
REQ-025 cs_n rising during WSETUP/WSTROBE/WHOLD SHALL NOT truncate the write sequence; return to IDLE after WHOLD.
REQ-026 miso SHALL be 0 whenever not in DATA of a read frame.
REQ-027 rw and regSel SHALL hold their last latched value between frames; rw SHALL return to 1 (read, bus released) in IDLE.
REQ-028 Exactly one en pulse SHALL be produced per valid write frame; none otherwise.

Reset
REQ-029 rst low SHALL immediately force: state IDLE, en=0, rw=1, regSel=4'b0000, dataOut=8'h00, dataOe=0, miso=0, frameErr=0, counters and shift registers 0, synchronizers to idle levels (sck=0, cs_n=1).
REQ-030 rst asserted mid-frame or mid-strobe SHALL discard the frame; after release a new frame SHALL be accepted from the next cs_n fall.

Verification
REQ-031 Write frame 0x07,0xA5 (EN_WIDTH=2) -> dataOut=0xA5, dataOe high 4 clks, en high 2 clks starting 1 clk after dataOe, rw=0, regSel=4'b0111, one en pulse.
REQ-032 Read frame 0x8E,0x00 with dataIn=0x3C -> miso shifts 0,0,1,1,1,1,0,0 during byte 1, rw=1, regSel=4'b1110, en never high.
REQ-033 Command 0x17 -> frameErr pulses once after bit 8, no en, state WAITCS until cs_n high.
REQ-034 cs_n raised after 12 bits of write 0x0B,0xFF -> no en, dataOe stays 0; next frame 0x0B,0x01 -> dataOut=0x01, one en pulse.
REQ-035 rst pulled low during WSTROBE -> en=0, dataOe=0, dataOut=0x00 asynchronously; after release frame 0x0D,0x55 completes normally.
REQ-036 Frame of 24 sck cycles 0x07,0x12,0xFF -> single en pulse with dataOut=0x12, third byte ignored.

Source files
------------

// File: rtl/spi_frame_ctrl_if.sv
// spi_frame_ctrl_if
//   Bundles the SPI slave pins and the 8-line register port driven by
//   spi_frame_ctrl. The controller connects through the slave modport; the
//   SPI master / port model connects through the master modport.
//   SPI side : sck, cs_n (active-low), mosi in; miso out (mode 0, MSB first)
//   Port side: en strobe, rw (1=read), regSel[3:0], dataOut[7:0], dataOe,
//              dataIn[7:0] read back from the port data bus
//   Status   : frameErr, one-clk pulse on a rejected command byte
interface spi_frame_ctrl_if;
  logic       sck;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       en;
  logic       rw;
  logic [3:0] regSel;
  logic [7:0] dataOut;
  logic       dataOe;
  logic [7:0] dataIn;
  logic       frameErr;

  modport slave (
    input  sck, cs_n, mosi, dataIn,
    output miso, en, rw, regSel, dataOut, dataOe, frameErr
  );

  modport master (
    output sck, cs_n, mosi, dataIn,
    input  miso, en, rw, regSel, dataOut, dataOe, frameErr
  );
endinterface

// File: rtl/spi_frame_ctrl.sv
// spi_frame_ctrl
//   SPI mode-0 slave that turns a 16-bit frame {command, data} into one
//   access on an 8-line register port. Command byte = {rw, 3'b000, regSel}.
//   Writes drive dataOut with a setup clock, an EN_WIDTH-clock en strobe and
//   a hold clock; reads capture dataIn and shift it out on miso.
//   Ports: clk    - system clock, all state on its rising edge
//          rst    - asynchronous active-low reset
//          bus    - spi_frame_ctrl_if.slave (SPI pins, port bus, frameErr)
//   Parameters: EN_WIDTH    - clocks en is held high (1..15)
//               SYNC_STAGES - synchronizer depth on sck/cs_n/mosi (2..3)
module spi_frame_ctrl #(
  parameter int EN_WIDTH    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  spi_frame_ctrl_if.slave       bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CMD     = 3'd1,
    DATA    = 3'd2,
    WSETUP  = 3'd3,
    WSTROBE = 3'd4,
    WHOLD   = 3'd5,
    WAITCS  = 3'd6
  } state_t;

  localparam logic [3:0] EN_LAST = 4'(EN_WIDTH - 1);

  logic [SYNC_STAGES-1:0] sckSync_r;
  logic [SYNC_STAGES-1:0] csSync_r;
  logic [SYNC_STAGES-1:0] mosiSync_r;
  logic                   sckPrev_r;
  logic                   csPrev_r;

  state_t     state_r;
  logic [3:0] bitCnt_r;
  logic [3:0] enCnt_r;
  logic [6:0] shift_r;
  logic [7:0] misoShift_r;
  logic       capPend_r;
  logic       en_r;
  logic       rw_r;
  logic [3:0] regSel_r;
  logic [7:0] dataOut_r;
  logic       dataOe_r;
  logic       frameErr_r;

  logic       sckS_s;
  logic       csS_s;
  logic       mosiS_s;
  logic       sckRise_s;
  logic       sckFall_s;
  logic       csFall_s;
  logic [7:0] nextShift_s;

  assign sckS_s      = sckSync_r[SYNC_STAGES-1];
  assign csS_s       = csSync_r[SYNC_STAGES-1];
  assign mosiS_s     = mosiSync_r[SYNC_STAGES-1];
  assign sckRise_s   = sckS_s & ~sckPrev_r;
  assign sckFall_s   = ~sckS_s & sckPrev_r;
  assign csFall_s    = ~csS_s & csPrev_r;
  // mosi travels through the same depth as sck, so it is stable at the rise
  assign nextShift_s = {shift_r, mosiS_s};

  assign bus.miso     = misoShift_r[7];
  assign bus.en       = en_r;
  assign bus.rw       = rw_r;
  assign bus.regSel   = regSel_r;
  assign bus.dataOut  = dataOut_r;
  assign bus.dataOe   = dataOe_r;
  assign bus.frameErr = frameErr_r;

  // Synchronize the asynchronous SPI pins and keep one-clock history for edges
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sckSync_r  <= {SYNC_STAGES{1'b0}};
      csSync_r   <= {SYNC_STAGES{1'b1}};
      mosiSync_r <= {SYNC_STAGES{1'b0}};
      sckPrev_r  <= 1'b0;
      csPrev_r   <= 1'b1;
    end else begin
      sckSync_r  <= {sckSync_r[SYNC_STAGES-2:0], bus.sck};
      csSync_r   <= {csSync_r[SYNC_STAGES-2:0], bus.cs_n};
      mosiSync_r <= {mosiSync_r[SYNC_STAGES-2:0], bus.mosi};
      sckPrev_r  <= sckS_s;
      csPrev_r   <= csS_s;
    end
  end

  // Frame state machine with all port-side outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= IDLE;
      bitCnt_r    <= 4'd0;
      enCnt_r     <= 4'd0;
      shift_r     <= 7'd0;
      misoShift_r <= 8'd0;
      capPend_r   <= 1'b0;
      en_r        <= 1'b0;
      rw_r        <= 1'b1;
      regSel_r    <= 4'd0;
      dataOut_r   <= 8'd0;
      dataOe_r    <= 1'b0;
      frameErr_r  <= 1'b0;
    end else begin
      frameErr_r <= 1'b0;
      case (state_r)
        IDLE: begin
          rw_r        <= 1'b1;
          misoShift_r <= 8'd0;
          if (csFall_s) begin
            state_r  <= CMD;
            bitCnt_r <= 4'd0;
            shift_r  <= 7'd0;
          end
        end
        CMD: begin
          if (csS_s) begin
            state_r  <= IDLE;
            bitCnt_r <= 4'd0;
            shift_r  <= 7'd0;
            rw_r     <= 1'b1;
          end else if (sckRise_s) begin
            shift_r <= nextShift_s[6:0];
            if (bitCnt_r == 4'd7) begin
              if (nextShift_s[6:4] != 3'b000) begin
                frameErr_r <= 1'b1;
                bitCnt_r   <= 4'd0;
                state_r    <= WAITCS;
              end else begin
                rw_r      <= nextShift_s[7];
                regSel_r  <= nextShift_s[3:0];
                capPend_r <= nextShift_s[7];
                bitCnt_r  <= 4'd8;
                state_r   <= DATA;
              end
            end else begin
              bitCnt_r <= bitCnt_r + 4'd1;
            end
          end
        end
        DATA: begin
          if (csS_s) begin
            state_r     <= IDLE;
            bitCnt_r    <= 4'd0;
            shift_r     <= 7'd0;
            misoShift_r <= 8'd0;
            capPend_r   <= 1'b0;
            rw_r        <= 1'b1;
          end else begin
            // Read data is taken one clock after regSel/rw reach the port.
            // The sck fall closing the command byte (bitCnt 8) must not shift,
            // otherwise bit 7 would be lost before the first data rise.
            if (capPend_r) begin
              misoShift_r <= bus.dataIn;
              capPend_r   <= 1'b0;
            end else if (sckFall_s && rw_r && (bitCnt_r >= 4'd9)) begin
              misoShift_r <= {misoShift_r[6:0], 1'b0};
            end
            if (sckRise_s) begin
              shift_r <= nextShift_s[6:0];
              if (bitCnt_r == 4'd15) begin
                bitCnt_r    <= 4'd0;
                misoShift_r <= 8'd0;
                if (rw_r) begin
                  state_r <= WAITCS;
                end else begin
                  dataOut_r <= nextShift_s;
                  dataOe_r  <= 1'b1;
                  state_r   <= WSETUP;
                end
              end else begin
                bitCnt_r <= bitCnt_r + 4'd1;
              end
            end
          end
        end
        WSETUP: begin
          en_r    <= 1'b1;
          enCnt_r <= 4'd0;
          state_r <= WSTROBE;
        end
        WSTROBE: begin
          if (enCnt_r == EN_LAST) begin
            en_r    <= 1'b0;
            enCnt_r <= 4'd0;
            state_r <= WHOLD;
          end else begin
            enCnt_r <= enCnt_r + 4'd1;
          end
        end
        WHOLD: begin
          dataOe_r <= 1'b0;
          state_r  <= WAITCS;
        end
        WAITCS: begin
          misoShift_r <= 8'd0;
          if (csS_s) begin
            state_r  <= IDLE;
            bitCnt_r <= 4'd0;
            shift_r  <= 7'd0;
            rw_r     <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// tb_spi_frame_ctrl
//   Directed bench for spi_frame_ctrl: drives SPI frames through the
//   interface, monitors en/dataOe/frameErr activity and compares against
//   hand-computed values.
module tb_spi_frame_ctrl;
  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_frame_ctrl_if busIf();

  spi_frame_ctrl #(.EN_WIDTH(2), .SYNC_STAGES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (busIf)
  );

  int checks    = 0;
  int errors    = 0;
  int cycle     = 0;
  int enPulses  = 0;
  int enHigh    = 0;
  int oeHigh    = 0;
  int errPulses = 0;
  int enRiseCyc = 0;
  int oeRiseCyc = 0;
  logic prevEn  = 1'b0;
  logic prevOe  = 1'b0;

  // Activity monitor, sampled away from the active edge
  always @(negedge clk) begin
    cycle = cycle + 1;
    if (busIf.en === 1'b1 && prevEn !== 1'b1) begin
      enPulses  = enPulses + 1;
      enRiseCyc = cycle;
    end
    if (busIf.en === 1'b1) enHigh = enHigh + 1;
    if (busIf.dataOe === 1'b1 && prevOe !== 1'b1) oeRiseCyc = cycle;
    if (busIf.dataOe === 1'b1) oeHigh = oeHigh + 1;
    if (busIf.frameErr === 1'b1) errPulses = errPulses + 1;
    prevEn = busIf.en;
    prevOe = busIf.dataOe;
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Clock nBits out of bits[23:...] MSB first; miso sampled before each data-byte rise
  task automatic xfer(input int nBits, input logic [23:0] bits, output logic [7:0] misoByte);
    misoByte = 8'h00;
    busIf.cs_n = 1'b0;
    for (int i = 0; i < nBits; i++) begin
      busIf.mosi = bits[23-i];
      repeat (HALF) @(posedge clk);
      @(negedge clk);
      if (i >= 8 && i < 16) misoByte[15-i] = busIf.miso;
      busIf.sck = 1'b1;
      repeat (HALF) @(posedge clk);
      @(negedge clk);
      busIf.sck = 1'b0;
    end
    repeat (HALF) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic endFrame();
    busIf.cs_n = 1'b1;
    busIf.mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  logic [7:0] mb;
  int p0, h0, o0, e0;

  initial begin
    rst          = 1'b0;
    busIf.sck    = 1'b0;
    busIf.cs_n   = 1'b1;
    busIf.mosi   = 1'b0;
    busIf.dataIn = 8'h00;
    repeat (3) @(negedge clk);
    checkVal("rstEn",      32'(busIf.en),       32'd0);
    checkVal("rstRw",      32'(busIf.rw),       32'd1);
    checkVal("rstRegSel",  32'(busIf.regSel),   32'd0);
    checkVal("rstDataOut", 32'(busIf.dataOut),  32'd0);
    checkVal("rstDataOe",  32'(busIf.dataOe),   32'd0);
    checkVal("rstMiso",    32'(busIf.miso),     32'd0);
    checkVal("rstErr",     32'(busIf.frameErr), 32'd0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Write 0x07,0xA5
    p0 = enPulses; h0 = enHigh; o0 = oeHigh;
    xfer(16, 24'h07A500, mb);
    checkVal("wrDataOut", 32'(busIf.dataOut), 32'h000000A5);
    checkVal("wrRw",      32'(busIf.rw),      32'd0);
    checkVal("wrRegSel",  32'(busIf.regSel),  32'd7);
    checkVal("wrEnPulses", enPulses - p0,     32'd1);
    checkVal("wrEnHigh",   enHigh - h0,       32'd2);
    checkVal("wrOeHigh",   oeHigh - o0,       32'd4);
    checkVal("wrEnDelay",  enRiseCyc - oeRiseCyc, 32'd1);
    checkVal("wrMiso",    32'(busIf.miso),    32'd0);
    endFrame();
    checkVal("idleRw",    32'(busIf.rw),      32'd1);

    // Read 0x8E with dataIn 0x3C
    busIf.dataIn = 8'h3C;
    h0 = enHigh;
    xfer(16, 24'h8E0000, mb);
    checkVal("rdMisoByte", 32'(mb),             32'h0000003C);
    checkVal("rdRw",       32'(busIf.rw),       32'd1);
    checkVal("rdRegSel",   32'(busIf.regSel),   32'hE);
    checkVal("rdEnHigh",   enHigh - h0,         32'd0);
    checkVal("rdMisoAfter", 32'(busIf.miso),    32'd0);
    endFrame();

    // Bad command 0x17, remaining bits must be ignored
    p0 = enPulses; e0 = errPulses;
    xfer(16, 24'h17AA00, mb);
    checkVal("errPulses",  errPulses - e0,     32'd1);
    checkVal("errNoEn",    enPulses - p0,      32'd0);
    checkVal("errRegSel",  32'(busIf.regSel),  32'hE);
    endFrame();

    // Abort after 12 bits, then a good frame
    p0 = enPulses; o0 = oeHigh;
    xfer(12, 24'h0BFF00, mb);
    endFrame();
    checkVal("abortNoEn",  enPulses - p0,      32'd0);
    checkVal("abortNoOe",  oeHigh - o0,        32'd0);
    p0 = enPulses;
    xfer(16, 24'h0B0100, mb);
    checkVal("postAbortData",  32'(busIf.dataOut), 32'h00000001);
    checkVal("postAbortEn",    enPulses - p0,      32'd1);
    checkVal("postAbortRegSel", 32'(busIf.regSel), 32'hB);
    endFrame();

    // Reset during the strobe
    xfer(15, 24'h0D5500, mb);
    busIf.mosi = 1'b1;
    busIf.sck  = 1'b1;
    for (int k = 0; k < 40 && busIf.en !== 1'b1; k++) @(negedge clk);
    checkVal("strobeSeen", 32'(busIf.en), 32'd1);
    rst = 1'b0;
    #1;
    checkVal("asyncEn",      32'(busIf.en),      32'd0);
    checkVal("asyncDataOe",  32'(busIf.dataOe),  32'd0);
    checkVal("asyncDataOut", 32'(busIf.dataOut), 32'd0);
    checkVal("asyncRegSel",  32'(busIf.regSel),  32'd0);
    busIf.sck  = 1'b0;
    busIf.cs_n = 1'b1;
    busIf.mosi = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    p0 = enPulses;
    xfer(16, 24'h0D5500, mb);
    checkVal("postRstData", 32'(busIf.dataOut), 32'h00000055);
    checkVal("postRstEn",   enPulses - p0,      32'd1);
    endFrame();

    // 24-bit frame, third byte ignored
    p0 = enPulses;
    xfer(24, 24'h0712FF, mb);
    checkVal("longEn",   enPulses - p0,      32'd1);
    checkVal("longData", 32'(busIf.dataOut), 32'h00000012);
    endFrame();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
